// File: rtl/branch_predictor_pkg.sv
// Shared helpers for the branch predictor: counter encodings and saturating
// arithmetic, written width-generic so any CTR_W up to 4 can use them.
package bp_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned CTR_W_MAX = 4;

  // Weakly-taken: MSB set, remaining bits clear.
  function automatic int unsigned CTR_WEAK_T(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Weakly-not-taken: MSB clear, remaining bits set (0 for a 1-bit counter).
  function automatic int unsigned CTR_WEAK_NT(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
    int unsigned max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter_stat.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter_stat #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor with saturating direction counters.
// Lookup is a combinational read of the flop table; training lands one edge later.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [31:0]       pc_if,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispred,
  output logic [STAT_W-1:0] stat_upd,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;

  localparam logic [CTR_W-1:0] CTR_INIT_T  = CTR_W'(CTR_WEAK_T(CTR_W));
  localparam logic [CTR_W-1:0] CTR_INIT_NT = CTR_W'(CTR_WEAK_NT(CTR_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT_NT};

  entry_t tbl_q [ENTRIES];
  entry_t tbl_d [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_upd_pc;

  // Only the index and tag slices of upd_pc steer the table.
  assign unused_upd_pc = ^upd_pc;

  assign lk_idx = pc_if[TAG_LO-1:2];
  assign lk_tag = pc_if[TAG_LO+TAG_W-1:TAG_LO];
  assign lk_hit = tbl_q[lk_idx].valid && (tbl_q[lk_idx].tag == lk_tag);

  assign pred_taken  = lk_hit && tbl_q[lk_idx].ctr[CTR_W-1];
  assign pred_target = pred_taken ? tbl_q[lk_idx].target : pc_if + 32'd4;

  assign up_idx = upd_pc[TAG_LO-1:2];
  assign up_tag = upd_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign up_hit = tbl_q[up_idx].valid && (tbl_q[up_idx].tag == up_tag);

  assign mispred = upd_valid &&
                   ((upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target)));

  always_comb begin
    tbl_d = tbl_q;
    if (clear) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_d[IDX_W'(i)].valid = 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          tbl_d[up_idx].ctr    = CTR_W'(sat_inc(32'(tbl_q[up_idx].ctr), CTR_W));
          tbl_d[up_idx].target = upd_target;
        end else begin
          tbl_d[up_idx].ctr = CTR_W'(sat_dec(32'(tbl_q[up_idx].ctr)));
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever aliased entry occupied this index.
        tbl_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_INIT_T};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_q[IDX_W'(i)] <= ENTRY_RST;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  sat_counter_stat #(.W(STAT_W)) u_stat_upd (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (upd_valid),
    .count_o (stat_upd)
  );

  sat_counter_stat #(.W(STAT_W)) u_stat_miss (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (mispred),
    .count_o (stat_miss)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations queued as stimulus is
// driven, then popped and checked once the outputs have settled.
module tb_branch_predictor;

  localparam int unsigned ENTRIES  = 16;
  localparam int unsigned CTR_W    = 2;
  localparam int unsigned TAG_W    = 8;
  localparam int unsigned STAT_W   = 4;
  localparam int unsigned STAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [31:0]       pc_if;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  logic              mispred;
  logic [STAT_W-1:0] stat_upd;
  logic [STAT_W-1:0] stat_miss;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W),
    .TAG_W   (TAG_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .pc_if           (pc_if),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispred         (mispred),
    .stat_upd        (stat_upd),
    .stat_miss       (stat_miss)
  );

  typedef enum logic [2:0] {S_PT, S_PTGT, S_MISP, S_SUPD, S_SMISS} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int unsigned tests  = 0;
  int unsigned fails  = 0;
  int unsigned n_upd  = 0;
  int unsigned n_miss = 0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_PT:    return {31'b0, pred_taken};
      S_PTGT:  return pred_target;
      S_MISP:  return {31'b0, mispred};
      S_SUPD:  return 32'(stat_upd);
      default: return 32'(stat_miss);
    endcase
  endfunction

  function automatic void push_exp(string n, sig_e s, logic [31:0] v);
    sbq.push_back('{name: n, sig: s, exp: v});
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sig);
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic lookup(string n, logic [31:0] pc, logic t, logic [31:0] tgt);
    pc_if = pc;
    push_exp({n, ".taken"}, S_PT, 32'(t));
    push_exp({n, ".target"}, S_PTGT, tgt);
    #1;
    drain();
  endtask

  task automatic stats(string n);
    push_exp({n, ".stat_upd"}, S_SUPD, n_upd);
    push_exp({n, ".stat_miss"}, S_SMISS, n_miss);
    drain();
  endtask

  task automatic update(string n, logic [31:0] pc, logic t, logic [31:0] tgt,
                        logic pt, logic [31:0] ptgt, logic exp_mp);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
    push_exp({n, ".mispred"}, S_MISP, 32'(exp_mp));
    #1;
    drain();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    if (n_upd < STAT_MAX) n_upd++;
    if (exp_mp && (n_miss < STAT_MAX)) n_miss++;
  endtask

  initial begin
    reset           = 1'b0;
    clear           = 1'b0;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    pc_if           = 32'h0040_0010;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    lookup("rst_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
    stats("rst");

    // First allocation; same-cycle lookup must still see the old contents.
    pc_if           = 32'h10;
    upd_valid       = 1'b1;
    upd_pc          = 32'h10;
    upd_taken       = 1'b1;
    upd_target      = 32'h40;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h14;
    push_exp("alloc.mispred", S_MISP, 32'd1);
    push_exp("nobypass.taken", S_PT, 32'd0);
    push_exp("nobypass.target", S_PTGT, 32'h14);
    #1;
    drain();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    n_upd++;
    n_miss++;
    lookup("alloc", 32'h10, 1'b1, 32'h40);
    stats("alloc");

    // Counter walk-down: 10 -> 01 -> 00 -> 00 -> 00
    update("nt1", 32'h10, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    lookup("nt1", 32'h10, 1'b0, 32'h14);
    update("nt2", 32'h10, 1'b0, 32'h0, 1'b0, 32'h14, 1'b0);
    lookup("nt2", 32'h10, 1'b0, 32'h14);
    update("nt3", 32'h10, 1'b0, 32'h0, 1'b0, 32'h14, 1'b0);
    update("nt4", 32'h10, 1'b0, 32'h0, 1'b0, 32'h14, 1'b0);
    lookup("nt4", 32'h10, 1'b0, 32'h14);

    // Walk back up: 00 -> 01 (still not taken) -> 10 -> 11 -> 11
    update("t1", 32'h10, 1'b1, 32'h40, 1'b0, 32'h14, 1'b1);
    lookup("t1", 32'h10, 1'b0, 32'h14);
    update("t2", 32'h10, 1'b1, 32'h80, 1'b0, 32'h14, 1'b1);
    lookup("t2", 32'h10, 1'b1, 32'h80);
    update("t3_badtgt", 32'h10, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1);
    update("t4_correct", 32'h10, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    update("top_nt", 32'h10, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    lookup("top_nt", 32'h10, 1'b1, 32'h80);
    stats("walk");

    // 0x50 shares index 4 with 0x10 but carries tag 1.
    update("alias", 32'h50, 1'b1, 32'h100, 1'b0, 32'h54, 1'b1);
    lookup("alias_old", 32'h10, 1'b0, 32'h14);
    lookup("alias_new", 32'h50, 1'b1, 32'h100);

    // Reset mid-run: state clears and the concurrent update is dropped.
    reset           = 1'b0;
    n_upd           = 0;
    n_miss          = 0;
    upd_valid       = 1'b1;
    upd_pc          = 32'h10;
    upd_taken       = 1'b1;
    upd_target      = 32'h40;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h14;
    push_exp("inrst.mispred", S_MISP, 32'd1);
    push_exp("inrst.stat_upd", S_SUPD, 32'd0);
    push_exp("inrst.stat_miss", S_SMISS, 32'd0);
    #1;
    drain();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    reset     = 1'b1;
    lookup("rstmid_alias", 32'h50, 1'b0, 32'h54);
    lookup("rstmid_ignored", 32'h10, 1'b0, 32'h14);
    stats("rstmid");

    // Clear wins over a same-cycle allocation.
    update("pre_clear", 32'h50, 1'b1, 32'h100, 1'b0, 32'h54, 1'b1);
    lookup("pre_clear", 32'h50, 1'b1, 32'h100);
    clear = 1'b1;
    update("clr_upd", 32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1);
    clear = 1'b0;
    lookup("clr_old", 32'h50, 1'b0, 32'h54);
    lookup("clr_new", 32'h200, 1'b0, 32'h204);
    lookup("clr_idx4", 32'h10, 1'b0, 32'h14);
    stats("clr_keeps_stats");

    // Statistics saturation with a 4-bit counter.
    reset  = 1'b0;
    n_upd  = 0;
    n_miss = 0;
    #1;
    stats("sat_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      update($sformatf("sat_%0d", i), 32'h1000 + 32'(4 * i), 1'b1, 32'h2000,
             1'b0, 32'h1004 + 32'(4 * i), 1'b1);
      stats($sformatf("sat_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
